// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, read-only instruction cache answering
// fetch requests.
//
// Hits are answered one edge after the request. A miss refills the whole
// line from memory, one outstanding word at a time, then answers with the
// requested word.
//
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   icache_rd_i/pc_i  fetch request (pc bit 0 ignored)
//   icache_valid_o    one-cycle response pulse
//   icache_instr_o    returned instruction, held until the next response
//   icache_rsp_pc_o   halfword-aligned pc of the answered request
//   icache_busy_o     refill in progress; requests are ignored
//   flush_i           invalidate every line
//   mem_rd_o/addr_o   memory word request
//   mem_valid_i/data_i memory word return
module icache_responder #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LINES  = 8,
  parameter int unsigned WORDS  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              icache_rd_i,
  input  logic [ADDR_W-1:0] icache_pc_i,
  output logic              icache_valid_o,
  output logic [DATA_W-1:0] icache_instr_o,
  output logic [ADDR_W-1:0] icache_rsp_pc_o,
  output logic              icache_busy_o,
  input  logic              flush_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int unsigned OFF_W   = $clog2(WORDS);
  localparam int unsigned IDX_W   = $clog2(LINES);
  localparam int unsigned TAG_LSB = 1 + OFF_W + IDX_W;
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;

  typedef enum logic {
    ST_IDLE,
    ST_REFILL
  } state_e;

  // Line storage; contents are only meaningful where valid_q is set.
  logic [DATA_W-1:0] data_mem [LINES][WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flushed_q, flushed_d;
  logic [DATA_W-1:0] capt_q, capt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              busy_q, busy_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              fill_we_c;
  logic              tag_we_c;
  logic              hit_c;
  logic              last_beat_c;

  // Request address fields.
  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [ADDR_W-1:0] req_pc;

  // Fields of the latched miss address.
  logic [OFF_W-1:0]  lat_off;
  logic [IDX_W-1:0]  lat_idx;
  logic [TAG_W-1:0]  lat_tag;

  // Bit 0 of the pc carries no information for halfword instructions.
  logic              unused_pc0;

  assign unused_pc0 = icache_pc_i[0];

  assign req_off = icache_pc_i[OFF_W:1];
  assign req_idx = icache_pc_i[OFF_W+IDX_W:OFF_W+1];
  assign req_tag = icache_pc_i[ADDR_W-1:TAG_LSB];
  assign req_pc  = {icache_pc_i[ADDR_W-1:1], 1'b0};

  assign lat_off = pc_q[OFF_W:1];
  assign lat_idx = pc_q[OFF_W+IDX_W:OFF_W+1];
  assign lat_tag = pc_q[ADDR_W-1:TAG_LSB];

  // A flush on the request edge forces a miss.
  assign hit_c       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush_i;
  assign last_beat_c = (cnt_q == OFF_W'(WORDS - 1));

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    flushed_d   = flushed_q;
    capt_d      = capt_q;
    rsp_valid_d = 1'b0;
    instr_d     = instr_q;
    rsp_pc_d    = rsp_pc_q;
    busy_d      = busy_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    fill_we_c   = 1'b0;
    tag_we_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          valid_d = '0;
        end
        if (icache_rd_i) begin
          if (hit_c) begin
            rsp_valid_d = 1'b1;
            instr_d     = data_mem[req_idx][req_off];
            rsp_pc_d    = req_pc;
          end else begin
            state_d    = ST_REFILL;
            pc_d       = req_pc;
            cnt_d      = '0;
            flushed_d  = 1'b0;
            busy_d     = 1'b1;
            mem_rd_d   = 1'b1;
            mem_addr_d = {req_tag, req_idx, {(OFF_W + 1){1'b0}}};
          end
        end
      end

      ST_REFILL: begin
        if (flush_i) begin
          valid_d   = '0;
          flushed_d = 1'b1;
        end
        if (mem_valid_i) begin
          fill_we_c = 1'b1;
          cnt_d     = OFF_W'(cnt_q + 1'b1);
          if (cnt_q == lat_off) begin
            capt_d = mem_data_i;
          end
          if (last_beat_c) begin
            // Final beat: install the line and answer the latched request.
            tag_we_c         = 1'b1;
            valid_d[lat_idx] = !(flushed_q || flush_i);
            rsp_valid_d      = 1'b1;
            instr_d          = (cnt_q == lat_off) ? mem_data_i : capt_q;
            rsp_pc_d         = pc_q;
            mem_rd_d         = 1'b0;
            busy_d           = 1'b0;
            flushed_d        = 1'b0;
            state_d          = ST_IDLE;
          end else begin
            mem_addr_d = {lat_tag, lat_idx, OFF_W'(cnt_q + 1'b1), 1'b0};
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      pc_q        <= '0;
      flushed_q   <= 1'b0;
      capt_q      <= '0;
      rsp_valid_q <= 1'b0;
      instr_q     <= '0;
      rsp_pc_q    <= '0;
      busy_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      flushed_q   <= flushed_d;
      capt_q      <= capt_d;
      rsp_valid_q <= rsp_valid_d;
      instr_q     <= instr_d;
      rsp_pc_q    <= rsp_pc_d;
      busy_q      <= busy_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Data and tag arrays need no reset: the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (fill_we_c) begin
      data_mem[lat_idx][cnt_q] <= mem_data_i;
    end
    if (tag_we_c) begin
      tag_mem[lat_idx] <= lat_tag;
    end
  end

  assign icache_valid_o  = rsp_valid_q;
  assign icache_instr_o  = instr_q;
  assign icache_rsp_pc_o = rsp_pc_q;
  assign icache_busy_o   = busy_q;
  assign mem_rd_o        = mem_rd_q;
  assign mem_addr_o      = mem_addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed scenarios plus a randomized run against a
// line-level model of a direct-mapped cache (8 lines x 4 halfwords).
// Backing memory holds 16'hA000 | address for every address used.
module tb_icache_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        icache_rd_i;
  logic [15:0] icache_pc_i;
  logic        icache_valid_o;
  logic [15:0] icache_instr_o;
  logic [15:0] icache_rsp_pc_o;
  logic        icache_busy_o;
  logic        flush_i;
  logic        mem_rd_o;
  logic [15:0] mem_addr_o;
  logic        mem_valid_i;
  logic [15:0] mem_data_i;

  int checks = 0;
  int errors = 0;
  int stall_mode = 0;   // 0: zero wait, 1: every 3rd cycle, 2: random
  int stall_cnt = 0;
  logic [15:0] beat_q[$];

  icache_responder dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .icache_rd_i     (icache_rd_i),
    .icache_pc_i     (icache_pc_i),
    .icache_valid_o  (icache_valid_o),
    .icache_instr_o  (icache_instr_o),
    .icache_rsp_pc_o (icache_rsp_pc_o),
    .icache_busy_o   (icache_busy_o),
    .flush_i         (flush_i),
    .mem_rd_o        (mem_rd_o),
    .mem_addr_o      (mem_addr_o),
    .mem_valid_i     (mem_valid_i),
    .mem_data_i      (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Backing memory, driven away from the active edge.
  always @(negedge clk_i) begin
    if (mem_rd_o) begin
      case (stall_mode)
        0:       mem_valid_i = 1'b1;
        1:       mem_valid_i = (stall_cnt % 3 == 2);
        default: mem_valid_i = ($urandom_range(0, 2) != 0);
      endcase
      stall_cnt  = stall_cnt + 1;
      mem_data_i = 16'hA000 | mem_addr_o;
    end else begin
      stall_cnt   = 0;
      mem_valid_i = 1'b0;
      mem_data_i  = 16'h0000;
    end
  end

  // Record the address of every accepted memory beat.
  always @(posedge clk_i) begin
    if (rst_ni && mem_rd_o && mem_valid_i) beat_q.push_back(mem_addr_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request, held for exactly one edge; returns at that edge + #1.
  task automatic send(input logic [15:0] pc, input logic fl);
    @(negedge clk_i);
    beat_q.delete();
    icache_rd_i = 1'b1;
    icache_pc_i = pc;
    flush_i     = fl;
    @(posedge clk_i);
    #1;
    icache_rd_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  // Wait (bounded) for a response; counts edges and busy samples.
  task automatic wait_rsp(output bit got, output int edges, output int busy_n);
    got    = 1'b0;
    edges  = 0;
    busy_n = int'(icache_busy_o);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i);
      #1;
      edges++;
      if (icache_valid_o) begin
        got = 1'b1;
        break;
      end
      if (icache_busy_o) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; icache_rd_i = 1'b0; icache_pc_i = '0; flush_i = 1'b0;
    mem_valid_i = 1'b0; mem_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (icache_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", icache_valid_o); end
    checks++; if (icache_instr_o !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0000", icache_instr_o); end
    checks++; if (icache_rsp_pc_o !== 16'h0) begin errors++; $display("FAIL reset_rsp_pc: got %h expected 0000", icache_rsp_pc_o); end
    checks++; if (icache_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", icache_busy_o); end
    checks++; if (mem_rd_o !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd_o); end
    checks++; if (mem_addr_o !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_cold_miss();
    bit got; int edges; int busy_n;
    stall_mode = 0;
    send(16'h0000, 1'b0);
    checks++; if (icache_valid_o !== 1'b0 || mem_rd_o !== 1'b1 || mem_addr_o !== 16'h0000) begin
      errors++; $display("FAIL cold_start: valid %b mem_rd %b addr %h expected 0 1 0000", icache_valid_o, mem_rd_o, mem_addr_o); end
    wait_rsp(got, edges, busy_n);
    checks++; if (got !== 1'b1 || edges != 4) begin errors++; $display("FAIL cold_latency: got %b edges %0d expected 1 4", got, edges); end
    checks++; if (busy_n != 4) begin errors++; $display("FAIL cold_busy: got %0d cycles expected 4", busy_n); end
    checks++; if (icache_instr_o !== 16'hA000 || icache_rsp_pc_o !== 16'h0000) begin
      errors++; $display("FAIL cold_rsp: instr %h pc %h expected a000 0000", icache_instr_o, icache_rsp_pc_o); end
    checks++; if (beat_q.size() != 4) begin errors++; $display("FAIL cold_beats: got %0d expected 4", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 4; i++) begin
      checks++; if (beat_q[i] !== 16'(2 * i)) begin errors++; $display("FAIL cold_beat_addr: beat %0d got %h expected %h", i, beat_q[i], 16'(2 * i)); end
    end
    checks++; if (mem_rd_o !== 1'b0) begin errors++; $display("FAIL cold_mem_rd_done: got %b expected 0", mem_rd_o); end
  endtask

  task automatic test_hits();
    logic [15:0] pc;
    for (int i = 1; i < 4; i++) begin
      pc = 16'(2 * i);
      send(pc, 1'b0);
      checks++; if (icache_valid_o !== 1'b1 || icache_instr_o !== (16'hA000 | pc) || icache_rsp_pc_o !== pc || mem_rd_o !== 1'b0) begin
        errors++; $display("FAIL hit: pc %h valid %b instr %h rsp_pc %h mem_rd %b", pc, icache_valid_o, icache_instr_o, icache_rsp_pc_o, mem_rd_o); end
    end
  endtask

  task automatic test_conflict_stall();
    bit got; int edges; int busy_n;
    stall_mode = 1;
    send(16'h0044, 1'b0);
    checks++; if (icache_busy_o !== 1'b1) begin errors++; $display("FAIL conflict_miss: busy %b expected 1", icache_busy_o); end
    wait_rsp(got, edges, busy_n);
    checks++; if (got !== 1'b1 || icache_instr_o !== 16'hA044 || icache_rsp_pc_o !== 16'h0044) begin
      errors++; $display("FAIL conflict_rsp: got %b instr %h pc %h expected 1 a044 0044", got, icache_instr_o, icache_rsp_pc_o); end
    checks++; if (edges < 12) begin errors++; $display("FAIL conflict_stall_len: got %0d edges expected >= 12", edges); end
    checks++; if (beat_q.size() != 4) begin errors++; $display("FAIL conflict_beats: got %0d expected 4", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 4; i++) begin
      checks++; if (beat_q[i] !== 16'(16'h0040 + 2 * i)) begin errors++; $display("FAIL conflict_beat_addr: beat %0d got %h", i, beat_q[i]); end
    end
    send(16'h0000, 1'b0);
    checks++; if (icache_valid_o !== 1'b0 || icache_busy_o !== 1'b1) begin
      errors++; $display("FAIL conflict_evict: valid %b busy %b expected 0 1", icache_valid_o, icache_busy_o); end
    wait_rsp(got, edges, busy_n);
    checks++; if (got !== 1'b1 || icache_instr_o !== 16'hA000) begin errors++; $display("FAIL conflict_refill: got %b instr %h expected 1 a000", got, icache_instr_o); end
    stall_mode = 0;
  endtask

  task automatic test_pc_change();
    bit got; int edges; int busy_n;
    stall_mode = 0;
    @(negedge clk_i);
    beat_q.delete();
    icache_rd_i = 1'b1; icache_pc_i = 16'h0100;
    @(posedge clk_i); #1;
    checks++; if (icache_busy_o !== 1'b1 || mem_addr_o !== 16'h0100) begin
      errors++; $display("FAIL branch_miss: busy %b addr %h expected 1 0100", icache_busy_o, mem_addr_o); end
    @(negedge clk_i);
    icache_pc_i = 16'h0200;
    wait_rsp(got, edges, busy_n);
    checks++; if (got !== 1'b1 || icache_rsp_pc_o !== 16'h0100 || icache_instr_o !== 16'hA100) begin
      errors++; $display("FAIL branch_rsp: got %b pc %h instr %h expected 1 0100 a100", got, icache_rsp_pc_o, icache_instr_o); end
    @(posedge clk_i); #1;
    icache_rd_i = 1'b0;
    checks++; if (icache_busy_o !== 1'b1 || mem_addr_o !== 16'h0200 || icache_valid_o !== 1'b0) begin
      errors++; $display("FAIL branch_new_miss: busy %b addr %h valid %b expected 1 0200 0", icache_busy_o, mem_addr_o, icache_valid_o); end
    wait_rsp(got, edges, busy_n);
    checks++; if (got !== 1'b1 || icache_instr_o !== 16'hA200 || icache_rsp_pc_o !== 16'h0200) begin
      errors++; $display("FAIL branch_new_rsp: got %b instr %h pc %h expected 1 a200 0200", got, icache_instr_o, icache_rsp_pc_o); end
  endtask

  task automatic test_flush();
    bit got; int edges; int busy_n;
    stall_mode = 0;
    send(16'h0000, 1'b0); wait_rsp(got, edges, busy_n);
    send(16'h0008, 1'b0); wait_rsp(got, edges, busy_n);
    send(16'h0000, 1'b0);
    checks++; if (icache_valid_o !== 1'b1 || icache_instr_o !== 16'hA000) begin errors++; $display("FAIL flush_pre_hit0: valid %b instr %h", icache_valid_o, icache_instr_o); end
    send(16'h0008, 1'b0);
    checks++; if (icache_valid_o !== 1'b1 || icache_instr_o !== 16'hA008) begin errors++; $display("FAIL flush_pre_hit8: valid %b instr %h", icache_valid_o, icache_instr_o); end
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    send(16'h0008, 1'b0);
    checks++; if (icache_valid_o !== 1'b0 || icache_busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_idle_miss: valid %b busy %b expected 0 1", icache_valid_o, icache_busy_o); end
    wait_rsp(got, edges, busy_n);
    checks++; if (got !== 1'b1 || icache_instr_o !== 16'hA008) begin errors++; $display("FAIL flush_refill: got %b instr %h expected 1 a008", got, icache_instr_o); end
    // Flush while 0x0010 is being refilled.
    stall_mode = 1;
    send(16'h0010, 1'b0);
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    wait_rsp(got, edges, busy_n);
    checks++; if (got !== 1'b1 || icache_instr_o !== 16'hA010 || icache_rsp_pc_o !== 16'h0010) begin
      errors++; $display("FAIL flush_mid_rsp: got %b instr %h pc %h expected 1 a010 0010", got, icache_instr_o, icache_rsp_pc_o); end
    stall_mode = 0;
    send(16'h0010, 1'b0);
    checks++; if (icache_valid_o !== 1'b0 || icache_busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_mid_not_valid: valid %b busy %b expected 0 1", icache_valid_o, icache_busy_o); end
    wait_rsp(got, edges, busy_n);
    send(16'h0008, 1'b0);
    checks++; if (icache_valid_o !== 1'b0 || icache_busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_mid_clears_all: valid %b busy %b expected 0 1", icache_valid_o, icache_busy_o); end
    wait_rsp(got, edges, busy_n);
  endtask

  task automatic test_reset_mid_refill();
    bit got; int edges; int busy_n;
    stall_mode = 0;
    send(16'h0020, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (beat_q.size() != 2) begin errors++; $display("FAIL rstmid_beats_before: got %0d expected 2", beat_q.size()); end
    rst_ni = 1'b0;
    #1;
    checks++; if (icache_valid_o !== 1'b0 || icache_instr_o !== 16'h0 || icache_rsp_pc_o !== 16'h0 ||
                  icache_busy_o !== 1'b0 || mem_rd_o !== 1'b0 || mem_addr_o !== 16'h0) begin
      errors++; $display("FAIL rstmid_outputs: valid %b instr %h pc %h busy %b mem_rd %b addr %h expected all 0",
                         icache_valid_o, icache_instr_o, icache_rsp_pc_o, icache_busy_o, mem_rd_o, mem_addr_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    send(16'h0020, 1'b0);
    checks++; if (icache_valid_o !== 1'b0 || icache_busy_o !== 1'b1 || mem_addr_o !== 16'h0020) begin
      errors++; $display("FAIL rstmid_miss: valid %b busy %b addr %h expected 0 1 0020", icache_valid_o, icache_busy_o, mem_addr_o); end
    wait_rsp(got, edges, busy_n);
    checks++; if (got !== 1'b1 || beat_q.size() != 4 || icache_instr_o !== 16'hA020) begin
      errors++; $display("FAIL rstmid_refill: got %b beats %0d instr %h expected 1 4 a020", got, beat_q.size(), icache_instr_o); end
  endtask

  // Random requests checked against a line-level model.
  task automatic test_random();
    bit got; int edges; int busy_n;
    bit          vm[8];
    int          tm[8];
    logic [15:0] pc;
    logic [15:0] apc;
    logic        fl;
    int          idx;
    int          tag;
    bit          exp_hit;
    @(negedge clk_i); flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    for (int i = 0; i < 8; i++) begin vm[i] = 1'b0; tm[i] = 0; end
    stall_mode = 2;
    for (int n = 0; n < 80; n++) begin
      pc  = 16'($urandom_range(0, 16'h03FF));
      fl  = ($urandom_range(0, 9) == 0);
      apc = pc & 16'hFFFE;
      idx = (int'(apc) / 8) % 8;
      tag = int'(apc) / 64;
      exp_hit = !fl && vm[idx] && (tm[idx] == tag);
      if (fl) for (int i = 0; i < 8; i++) vm[i] = 1'b0;
      send(pc, fl);
      if (exp_hit) begin
        checks++; if (icache_valid_o !== 1'b1 || icache_instr_o !== (16'hA000 | apc) || icache_rsp_pc_o !== apc || mem_rd_o !== 1'b0) begin
          errors++; $display("FAIL rand_hit: pc %h valid %b instr %h rsp_pc %h mem_rd %b", pc, icache_valid_o, icache_instr_o, icache_rsp_pc_o, mem_rd_o); end
      end else begin
        checks++; if (icache_valid_o !== 1'b0 || icache_busy_o !== 1'b1 || mem_addr_o !== (apc & 16'hFFF8)) begin
          errors++; $display("FAIL rand_miss_start: pc %h valid %b busy %b addr %h", pc, icache_valid_o, icache_busy_o, mem_addr_o); end
        wait_rsp(got, edges, busy_n);
        checks++; if (got !== 1'b1 || icache_instr_o !== (16'hA000 | apc) || icache_rsp_pc_o !== apc || beat_q.size() != 4) begin
          errors++; $display("FAIL rand_miss_rsp: pc %h got %b instr %h rsp_pc %h beats %0d", pc, got, icache_instr_o, icache_rsp_pc_o, beat_q.size()); end
        vm[idx] = 1'b1;
        tm[idx] = tag;
      end
    end
    stall_mode = 0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict_stall();
    test_pc_change();
    test_flush();
    test_reset_mid_refill();
    test_random();
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped instruction cache; the responder end of the fetch unit's icache request interface (icache_rd/icache_pc in, icache_valid/icache_instr out).
- Sits between the fetch stage and the backing instruction memory.
- Serves hits with 1-cycle latency.
- On a miss it refills a whole line from memory over a single-outstanding rd/valid handshake, then returns the requested word.
- Supports a single-cycle flush of all lines.

Parameters:
- ADDR_W, 16, fetch PC / memory address width (byte address; instructions are 16-bit and halfword aligned).
- DATA_W, 16, instruction / memory word width.
- LINES, 8, number of cache lines (power of 2, >=2).
- WORDS, 4, 16-bit words per line (power of 2, >=2).

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- icache_rd_i  in  1  fetch read request, sampled each edge.
- icache_pc_i  in  ADDR_W  request PC; bit 0 ignored.
- icache_valid_o  out  1  response valid, 1-cycle pulse per response.
- icache_instr_o  out  DATA_W  returned instruction; held until the next response.
- icache_rsp_pc_o  out  ADDR_W  PC (bit 0 forced 0) of the request being answered; lets fetch discard stale responses after a branch.
- icache_busy_o  out  1  high while in REFILL; requests are not accepted.
- flush_i  in  1  invalidate all lines.
- mem_rd_o  out  1  memory word request.
- mem_addr_o  out  ADDR_W  memory word address.
- mem_valid_i  in  1  memory word returned; only meaningful while mem_rd_o=1.
- mem_data_i  in  DATA_W  memory word data.

Behaviour:
- Address split: offset = pc[log2(WORDS):1], index = next log2(LINES) bits, tag = remaining upper bits. With defaults: offset pc[2:1], index pc[5:3], tag pc[15:6].
- Storage: data array LINES x WORDS x DATA_W; tag array; one valid bit per line.
- Reset (async, rst_ni=0):
  - All valid bits 0; state IDLE.
  - icache_valid_o=0, icache_instr_o=0, icache_rsp_pc_o=0, icache_busy_o=0, mem_rd_o=0, mem_addr_o=0, refill counter 0.
  - Reset mid-refill abandons the refill; the partially filled line stays invalid.
- State IDLE:
  - A request is accepted when icache_rd_i=1 at an edge.
  - Hit (valid[index] and tag match, flush_i=0): at that edge icache_valid_o<=1, icache_instr_o<=word, icache_rsp_pc_o<=pc. Stay in IDLE. Back-to-back hits give 1 response/cycle.
  - Miss: latch the pc, set counter=0, go to REFILL. icache_valid_o<=0, mem_rd_o<=1, mem_addr_o<={tag,index,0 offset,0}.
  - No request: icache_valid_o<=0.
- State REFILL:
  - mem_rd_o is held high; mem_addr_o = line base + 2*counter.
  - Each edge with mem_valid_i=1 writes mem_data_i into word[counter] and increments the counter. mem_valid_i=0 stalls indefinitely with no timeout.
  - If the accepted word equals the latched offset, it is also captured for the response.
  - On the edge accepting word WORDS-1:
    - mem_rd_o<=0.
    - tag is written.
    - valid<=1 unless a flush was seen during this refill.
    - icache_valid_o<=1 with the captured word and the latched pc.
    - Return to IDLE.
  - icache_rd_i and icache_pc_i are ignored during REFILL; icache_busy_o=1. The response always answers the latched pc, even if fetch changed pc (branch).
  - Miss latency with zero-wait memory: request edge T, beats accepted at T+1..T+WORDS, icache_valid_o high in the cycle after edge T+WORDS. Hit latency is 1 edge.
- Replacement: direct-mapped. A miss overwrites the line at index regardless of its valid bit.
- flush_i:
  - In IDLE: clears all valid bits at that edge. A simultaneous request is treated as a miss.
  - In REFILL: clears all valid bits, sets a sticky "flushed" flag, and the line being filled is not marked valid at completion. The response is still delivered.
  - The flag clears on return to IDLE.
- A miss to a line whose tag differs from its valid entry evicts it; no writeback is needed because the cache is read-only.

Test Plan:
- Cold miss: reset, rd pc=0x0000; memory returns data = 0xA000|addr with zero wait -> mem_addr_o 0x0000,0x0002,0x0004,0x0006 on consecutive cycles; icache_valid_o=1 with instr=0xA000, rsp_pc=0x0000 after 5 edges; busy high for 4 cycles.
- Hits: then rd 0x0002, 0x0004, 0x0006 back-to-back -> valid each cycle with 0xA002, 0xA004, 0xA006; mem_rd_o stays 0.
- Conflict miss with stalled memory: rd 0x0044 (same index 0, tag 1), mem_valid_i asserted only every 3rd cycle -> 4 beats at 0x0040..0x0046, response 0xA044. A following rd 0x0000 misses again.
- Pc change during refill: rd 0x0100 (miss), fetch switches pc to 0x0200 mid-refill -> response carries rsp_pc=0x0100 and instr=0xA100; then 0x0200 is accepted as a new miss.
- Flush: after lines 0x0000 and 0x0008 are cached, pulse flush_i -> next rd 0x0008 misses. Flush during a refill of 0x0010 -> response still delivered, but a subsequent rd 0x0010 misses.
- Reset mid-refill: drop rst_ni after 2 beats of a 0x0020 refill -> all outputs 0 immediately; after release, rd 0x0020 misses and refills all 4 words.
